lut_interp_activation_pipe: RTL
===============================

Name: lut_interp_activation_pipe

Overview:
- Pipelined, runtime-programmable activation unit: piecewise-linear LUT lookup plus linear interpolation on signed fixed-point inputs.
- Parametrised successor of the fixed 8-bit / 16-entry combinational activation function, generalised in data width and table depth.
- Adds a valid/ready stream, backpressure, and a LUT write port.
- Sits between a layer's MAC accumulator output (z) and the next layer's input (a).

Parameters:
- DATA_W, 8, signed width of z, a and LUT entries (>= ADDR_W+2).
- ADDR_W, 4, number of z MSBs used as LUT index; table depth = 2^ADDR_W.
- FRAC_W, DATA_W-ADDR_W, derived (localparam): width of the interpolation remainder.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  z_value is valid.
- in_ready  out  1  unit accepts z_value this cycle.
- z_value  in  DATA_W  signed pre-activation input.
- out_valid  out  1  a is valid.
- out_ready  in  1  downstream accepts a.
- a  out  DATA_W  signed activation result.
- lut_we  in  1  LUT write strobe.
- lut_waddr  in  ADDR_W  LUT write index.
- lut_wdata  in  DATA_W  signed LUT write value.

Behaviour:
- Reset (async, any time incl. mid-stream):
  - all stage valids = 0, out_valid = 0, a = 0.
  - all LUT entries = 0.
  - in-flight data discarded.
- Pipeline advance: adv = !out_valid | out_ready. Whole pipe advances or holds together. in_ready = adv (combinational).
- Accept: a word is taken when in_valid & in_ready.
- S1 (capture):
  - addr = z_value[DATA_W-1 -: ADDR_W], unsigned raw bits, so two's-complement order.
  - rem = z_value[FRAC_W-1:0], zero-extended.
  - v1 = accept.
- S2 (lookup):
  - base = LUT[addr].
  - Next index: addr+1 mod 2^ADDR_W, except addr = 2^(ADDR_W-1)-1 (most-positive bucket), where next = base (flat extrapolation, no jump to the most-negative entry).
  - addr = all-ones (the -1 bucket) wraps to LUT[0]; this is correct.
- S3 (interpolate):
  - prod = (next - base) * rem, signed, DATA_W+FRAC_W+2 bits.
  - a = base + (prod >>> FRAC_W), arithmetic shift (floor).
  - The result always lies between base and next inclusive; truncation to DATA_W is lossless and no saturation logic is needed.
- Latency and throughput:
  - Exactly 3 clk edges from accept to out_valid when out_ready is held high.
  - Throughput 1 result per cycle.
  - Output order equals input order.
- Backpressure: while out_valid & !out_ready, a and all stage registers hold stable and in_ready = 0.
- LUT writes:
  - Registered array; a write lands at the clk edge.
  - S2 reading the same index in the same cycle gets the pre-write value.
  - Writes are accepted regardless of stream state, including during stall.
- Simultaneous accept and output handshake in one cycle: both occur, with no bubble.

Optional Feature:
- Macro: LUT_INTERP_ROUND_EN.
- Defined: S3 uses a = base + ((prod + 2^(FRAC_W-1)) >>> FRAC_W), i.e. round-half-up. The result is still within [base, next], so there is no overflow.
- Undefined: floor shift as above.
- Latency, ports and handshake are identical in both builds.

Test Plan:
- Reset/latency:
  - Stimulus: rst pulse, then LUT[2]=16, LUT[3]=48; z=0x28 with out_ready=1.
  - Required: in_ready=1 right after reset; a=32 with out_valid exactly 3 cycles after accept; a=0 and out_valid=0 during reset.
- Positive-edge clamp:
  - Stimulus: LUT[7]=100, LUT[8]=-100, z=0x7F.
  - Required: a=100 (no interpolation toward -100).
- Negative wrap:
  - Stimulus: LUT[15]=-16, LUT[0]=0, z=0xF8.
  - Required: a=-8.
- Backpressure:
  - Stimulus: stream z=0x00,0x10,0x20,0x30 back-to-back (LUT[i]=i*10) with out_ready=0 from cycle 2 for 5 cycles, then 1.
  - Required: in_ready drops; a holds stable; outputs 0,10,20,30 in order with none lost or duplicated.
- Rounding:
  - Stimulus: LUT[0]=0, LUT[1]=1, z=0x08.
  - Required: a=0 without macro, a=1 with LUT_INTERP_ROUND_EN.
  - Stimulus: LUT[0]=1, LUT[1]=0, z=0x08.
  - Required: a=0 without macro, a=1 with it.
- Write collision/reset mid-stream:
  - Stimulus: write LUT[2]=50 in the same cycle S2 reads index 2 (old value 16, z=0x20).
  - Required: a=16; the next z=0x20 gives a=50.
  - Stimulus: assert rst with 2 words in flight.
  - Required: out_valid=0 immediately; no stale output after release.

Source files
------------

// File: rtl/lut_interp_activation_pipe_if.sv
// Stream and LUT-write bundle for lut_interp_activation_pipe.
// master: producer/consumer side (drives z, out_ready, LUT writes).
// slave:  the activation unit itself.
interface lut_interp_activation_pipe_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] z_value;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] a;
    logic                     lut_we;
    logic        [ADDR_W-1:0] lut_waddr;
    logic signed [DATA_W-1:0] lut_wdata;

    modport master (
        output in_valid, z_value, out_ready, lut_we, lut_waddr, lut_wdata,
        input  in_ready, out_valid, a
    );

    modport slave (
        input  in_valid, z_value, out_ready, lut_we, lut_waddr, lut_wdata,
        output in_ready, out_valid, a
    );
endinterface

// File: rtl/lut_interp_activation_pipe.sv
// Three-stage piecewise-linear activation: LUT lookup on the z MSBs plus
// linear interpolation on the remaining bits. Runtime-writable table.
// Optional build macro LUT_INTERP_ROUND_EN: round-half-up instead of floor
// in the interpolation shift.
module lut_interp_activation_pipe #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    lut_interp_activation_pipe_if.slave bus
);
    localparam int unsigned FRAC_W = DATA_W - ADDR_W;
    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned PROD_W = DATA_W + FRAC_W + 2;
    // Most-positive bucket: its "next" entry is clamped to itself.
    localparam logic [ADDR_W-1:0] ADDR_MAXPOS = ADDR_W'((DEPTH / 2) - 1);
`ifdef LUT_INTERP_ROUND_EN
    localparam logic signed [PROD_W-1:0] RND_HALF = PROD_W'(1) << (FRAC_W - 1);
`endif

    logic signed [DATA_W-1:0] lut_q [DEPTH];

    logic                     adv;
    logic                     v1_q, v2_q, out_valid_q;
    logic        [ADDR_W-1:0] addr1_q, addr1_d, addr_inc;
    logic        [FRAC_W-1:0] rem1_q, rem1_d, rem2_q;
    logic signed [DATA_W-1:0] base2_q, base2_d;
    logic signed [DATA_W-1:0] next2_q, next2_d;
    logic signed [DATA_W-1:0] a_q, a_d;
    logic signed [PROD_W-1:0] diff_ext, rem_ext, prod, prod_adj;

    // Handshake, stage-1 decode, stage-2 lookup and stage-3 interpolation.
    always_comb begin
        adv      = !out_valid_q || bus.out_ready;

        addr1_d  = bus.z_value[DATA_W-1 -: ADDR_W];
        rem1_d   = bus.z_value[FRAC_W-1:0];

        addr_inc = addr1_q + ADDR_W'(1);
        base2_d  = lut_q[addr1_q];
        next2_d  = (addr1_q == ADDR_MAXPOS) ? base2_d : lut_q[addr_inc];

        diff_ext = PROD_W'(next2_q) - PROD_W'(base2_q);
        rem_ext  = PROD_W'({1'b0, rem2_q});
        prod     = diff_ext * rem_ext;
`ifdef LUT_INTERP_ROUND_EN
        prod_adj = prod + RND_HALF;
`else
        prod_adj = prod;
`endif
        // Result lies in [base, next], so the truncation is lossless.
        a_d      = base2_q + DATA_W'(prod_adj >>> FRAC_W);
    end

    // Pipeline registers; the whole pipe advances or holds together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            addr1_q     <= '0;
            rem1_q      <= '0;
            rem2_q      <= '0;
            base2_q     <= '0;
            next2_q     <= '0;
            a_q         <= '0;
        end else if (adv) begin
            v1_q        <= bus.in_valid;
            addr1_q     <= addr1_d;
            rem1_q      <= rem1_d;
            v2_q        <= v1_q;
            base2_q     <= base2_d;
            next2_q     <= next2_d;
            rem2_q      <= rem1_q;
            out_valid_q <= v2_q;
            a_q         <= a_d;
        end
    end

    // Table storage; writes land at the edge, same-edge reads see old data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                lut_q[i] <= '0;
            end
        end else if (bus.lut_we) begin
            lut_q[bus.lut_waddr] <= bus.lut_wdata;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.a         = a_q;
endmodule
